// File: rtl/mem_req_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_req_stage
//  Description : Memory pipeline stage between execute and writeback. Holds
//                the M pipeline register under the valid/allowin handshake,
//                issues load/store requests on a req/addr_ok/data_ok data
//                bus, tracks outstanding data-phase transactions and produces
//                store strobes, replicated write data and misalignment flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_req_stage #(
    parameter int MAX_OST = 1
) (
    input  logic        clk,
    input  logic        reset,

    // pipeline handshake
    input  logic        valid_last,
    output logic        allowin,
    input  logic        allowin_next,
    output logic        ready_go,
    output logic        valid,

    // pipeline payload from E
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] ext_i,
    input  logic [31:0] mdu_i,
    input  logic [31:0] cp0_i,
    input  logic [31:0] rt_i,
    input  logic        mem_load_i,
    input  logic        mem_store_i,
    input  logic [1:0]  mem_size_i,

    // pipeline payload to W
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic [31:0] alu_o,
    output logic [31:0] ext_o,
    output logic [31:0] mdu_o,
    output logic [31:0] cp0_o,
    output logic        addr_err_o,

    // data bus
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    output logic [3:0]  data_wstrb,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);

    // Counter is two bits wide, so the limit is taken from the low bits.
    localparam logic [1:0] OST_LIMIT = MAX_OST[1:0];

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_REQ  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] store_data;
    logic        is_load;
    logic        is_store;
    logic [1:0]  mem_size;
    logic [1:0]  ost;

    logic        is_mem;
    logic        slot_free;
    logic        in_mem;
    logic        in_misaligned;
    logic        addr_inc;
    logic        data_dec;

    // Size 3 is reserved and behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] low);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = low[0];
            default:   bad = (low != 2'b00);
        endcase
        return bad;
    endfunction

    // Handshake and status flags derived from the resident instruction.
    always_comb begin
        is_mem        = is_load || is_store;
        in_mem        = mem_load_i || mem_store_i;
        in_misaligned = misaligned(mem_size_i, alu_i[1:0]);
        addr_err_o    = valid && is_mem && misaligned(mem_size, alu_o[1:0]);
        ready_go      = !valid || !is_mem || addr_err_o || (state == S_DONE);
        allowin       = !valid || (ready_go && allowin_next);
        // A returning data_ok frees a slot in the same cycle it is seen.
        slot_free     = (ost < OST_LIMIT) ||
                        ((ost == OST_LIMIT) && data_data_ok);
    end

    // M pipeline register: latch a new instruction whenever M can accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid      <= 1'b0;
            pc_o       <= '0;
            instr_o    <= '0;
            alu_o      <= '0;
            ext_o      <= '0;
            mdu_o      <= '0;
            cp0_o      <= '0;
            store_data <= '0;
            is_load    <= 1'b0;
            is_store   <= 1'b0;
            mem_size   <= '0;
        end else if (allowin) begin
            valid <= valid_last;
            if (valid_last) begin
                pc_o       <= pc_i;
                instr_o    <= instr_i;
                alu_o      <= alu_i;
                ext_o      <= ext_i;
                mdu_o      <= mdu_i;
                cp0_o      <= cp0_i;
                store_data <= rt_i;
                is_load    <= mem_load_i;
                is_store   <= mem_store_i;
                mem_size   <= mem_size_i;
            end
        end
    end

    // Request state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next request state: a latch decides the new instruction's state,
    // otherwise the resident instruction advances through its request.
    always_comb begin
        state_next = state;
        if (allowin) begin
            if (valid_last && in_mem && !in_misaligned) begin
                state_next = slot_free ? S_REQ : S_WAIT;
            end else begin
                state_next = S_IDLE;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    // The request is already visible this cycle when a slot
                    // frees, so an accepting addr_ok completes it directly.
                    if (slot_free) begin
                        state_next = data_addr_ok ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE:  state_next = S_DONE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Data bus request signals, held stable from the registered fields.
    always_comb begin
        data_req  = valid && ((state == S_REQ) ||
                              ((state == S_WAIT) && slot_free));
        data_wr   = is_store;
        data_size = mem_size;
        data_addr = alu_o;
    end

    // Store data replication and byte strobes by access size.
    always_comb begin
        data_wdata = store_data;
        data_wstrb = 4'b0000;
        case (mem_size)
            SIZE_BYTE: begin
                data_wdata = {4{store_data[7:0]}};
                data_wstrb = 4'b0001 << alu_o[1:0];
            end
            SIZE_HALF: begin
                data_wdata = {2{store_data[15:0]}};
                data_wstrb = alu_o[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                data_wdata = store_data;
                data_wstrb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            data_wstrb = 4'b0000;
        end
    end

    // Outstanding-transaction bookkeeping terms.
    always_comb begin
        addr_inc = data_req && data_addr_ok;
        data_dec = data_data_ok && (ost != 2'd0);
    end

    // Outstanding counter: saturates at the limit, ignores stray data_ok.
    always_ff @(posedge clk) begin
        if (reset) begin
            ost <= 2'd0;
        end else if (addr_inc && !data_dec) begin
            if (ost != OST_LIMIT) begin
                ost <= ost + 2'd1;
            end
        end else if (data_dec && !addr_inc) begin
            ost <= ost - 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_req_stage
//  Description : Directed self-checking bench for mem_req_stage (MAX_OST=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_stage;

    logic        clk;
    logic        reset;
    logic        valid_last;
    logic        allowin;
    logic        allowin_next;
    logic        ready_go;
    logic        valid;
    logic [31:0] pc_i, instr_i, alu_i, ext_i, mdu_i, cp0_i, rt_i;
    logic        mem_load_i, mem_store_i;
    logic [1:0]  mem_size_i;
    logic [31:0] pc_o, instr_o, alu_o, ext_o, mdu_o, cp0_o;
    logic        addr_err_o;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;

    int tests = 0;
    int fails = 0;

    mem_req_stage #(.MAX_OST(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_last   (valid_last),
        .allowin      (allowin),
        .allowin_next (allowin_next),
        .ready_go     (ready_go),
        .valid        (valid),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .alu_i        (alu_i),
        .ext_i        (ext_i),
        .mdu_i        (mdu_i),
        .cp0_i        (cp0_i),
        .rt_i         (rt_i),
        .mem_load_i   (mem_load_i),
        .mem_store_i  (mem_store_i),
        .mem_size_i   (mem_size_i),
        .pc_o         (pc_o),
        .instr_o      (instr_o),
        .alu_o        (alu_o),
        .ext_o        (ext_o),
        .mdu_o        (mdu_o),
        .cp0_o        (cp0_o),
        .addr_err_o   (addr_err_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic load_instr(input logic [31:0] p, input logic [31:0] ins,
                              input logic [31:0] a, input logic [31:0] r,
                              input logic ld, input logic st, input logic [1:0] sz);
        valid_last  = 1'b1;
        pc_i        = p;
        instr_i     = ins;
        alu_i       = a;
        rt_i        = r;
        ext_i       = p ^ 32'h5555_0000;
        mdu_i       = p ^ 32'h0000_AAAA;
        cp0_i       = p ^ 32'hFFFF_FFFF;
        mem_load_i  = ld;
        mem_store_i = st;
        mem_size_i  = sz;
    endtask

    task automatic bubble;
        valid_last  = 1'b0;
        mem_load_i  = 1'b0;
        mem_store_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; allowin_next = 1'b1;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        pc_i = '0; instr_i = '0; alu_i = '0; ext_i = '0; mdu_i = '0; cp0_i = '0; rt_i = '0;
        mem_size_i = 2'd0;
        bubble();
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_req", {31'd0, data_req}, 32'd0);
        chk("rst_ready_go", {31'd0, ready_go}, 32'd1);
        chk("rst_allowin", {31'd0, allowin}, 32'd1);
        chk("rst_addr_err", {31'd0, addr_err_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);

        // SW 0x100 with addr_ok already high
        load_instr(32'h1000, 32'hAC00_0000, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2);
        data_addr_ok = 1'b1;
        tick(); bubble(); #1;
        chk("sw_req", {31'd0, data_req}, 32'd1);
        chk("sw_wr", {31'd0, data_wr}, 32'd1);
        chk("sw_wstrb", {28'd0, data_wstrb}, 32'hF);
        chk("sw_wdata", data_wdata, 32'hDEAD_BEEF);
        chk("sw_addr", data_addr, 32'h100);
        chk("sw_size", {30'd0, data_size}, 32'd2);
        chk("sw_ready_go", {31'd0, ready_go}, 32'd0);
        chk("sw_allowin", {31'd0, allowin}, 32'd0);
        chk("sw_pc", pc_o, 32'h1000);
        chk("sw_ext", ext_o, 32'h5555_1000);
        tick();
        // LW arrives as SW leaves; SW's data phase is still outstanding
        load_instr(32'h1004, 32'h8C00_0000, 32'h200, 32'h0, 1'b1, 1'b0, 2'd2);
        data_addr_ok = 1'b0; #1;
        chk("sw_done_ready_go", {31'd0, ready_go}, 32'd1);
        chk("sw_done_req", {31'd0, data_req}, 32'd0);
        chk("sw_done_allowin", {31'd0, allowin}, 32'd1);
        tick(); bubble(); #1;
        chk("lw_wait_req", {31'd0, data_req}, 32'd0);
        chk("lw_wait_valid", {31'd0, valid}, 32'd1);
        chk("lw_wait_allowin", {31'd0, allowin}, 32'd0);
        chk("lw_pc", pc_o, 32'h1004);
        tick(); #1;
        chk("lw_wait2_req", {31'd0, data_req}, 32'd0);
        data_data_ok = 1'b1; #1;
        chk("lw_dok_req", {31'd0, data_req}, 32'd1);
        tick(); data_data_ok = 1'b0; #1;
        chk("lw_req", {31'd0, data_req}, 32'd1);
        chk("lw_wr", {31'd0, data_wr}, 32'd0);
        chk("lw_wstrb", {28'd0, data_wstrb}, 32'h0);
        chk("lw_addr", data_addr, 32'h200);
        data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; #1;
        chk("lw_done_ready_go", {31'd0, ready_go}, 32'd1);
        data_data_ok = 1'b1;
        tick(); data_data_ok = 1'b0; #1;
        chk("lw_left_valid", {31'd0, valid}, 32'd0);

        // SB 0x103
        load_instr(32'h1008, 32'hA000_0000, 32'h103, 32'h0000_00A5, 1'b0, 1'b1, 2'd0);
        data_addr_ok = 1'b1;
        tick(); bubble(); #1;
        chk("sb_req", {31'd0, data_req}, 32'd1);
        chk("sb_wstrb", {28'd0, data_wstrb}, 32'h8);
        chk("sb_wdata", data_wdata, 32'hA5A5_A5A5);
        tick();
        // SH 0x102 latched as SB leaves; SB's data_ok frees the slot now
        load_instr(32'h100C, 32'hA400_0000, 32'h102, 32'h0000_1234, 1'b0, 1'b1, 2'd1);
        data_data_ok = 1'b1; data_addr_ok = 1'b0;
        tick(); bubble(); data_data_ok = 1'b0; #1;
        chk("sh_req", {31'd0, data_req}, 32'd1);
        chk("sh_wstrb", {28'd0, data_wstrb}, 32'hC);
        chk("sh_wdata", data_wdata, 32'h1234_1234);
        chk("sh_size", {30'd0, data_size}, 32'd1);
        data_addr_ok = 1'b1;
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
        chk("sh_ready_go", {31'd0, ready_go}, 32'd1);
        tick(); data_data_ok = 1'b0;

        // LW 0x104 with addr_ok delayed three cycles
        load_instr(32'h1010, 32'h8C00_0004, 32'h104, 32'h0, 1'b1, 1'b0, 2'd2);
        tick(); bubble();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lwd_req", {31'd0, data_req}, 32'd1);
            chk("lwd_addr", data_addr, 32'h104);
            chk("lwd_allowin", {31'd0, allowin}, 32'd0);
            tick();
        end
        data_addr_ok = 1'b1; #1;
        chk("lwd_req4", {31'd0, data_req}, 32'd1);
        chk("lwd_size4", {30'd0, data_size}, 32'd2);
        tick(); data_addr_ok = 1'b0; data_data_ok = 1'b1; #1;
        chk("lwd_ready_go", {31'd0, ready_go}, 32'd1);
        chk("lwd_done_req", {31'd0, data_req}, 32'd0);
        tick(); data_data_ok = 1'b0;

        // LH 0x101 misaligned, then a non-memory ADD
        load_instr(32'h1018, 32'h8400_0000, 32'h101, 32'h0, 1'b1, 1'b0, 2'd1);
        tick();
        load_instr(32'h101C, 32'h0000_0020, 32'h5, 32'h0, 1'b0, 1'b0, 2'd0);
        #1;
        chk("lh_err", {31'd0, addr_err_o}, 32'd1);
        chk("lh_req", {31'd0, data_req}, 32'd0);
        chk("lh_ready_go", {31'd0, ready_go}, 32'd1);
        chk("lh_allowin", {31'd0, allowin}, 32'd1);
        tick(); bubble(); #1;
        chk("add_valid", {31'd0, valid}, 32'd1);
        chk("add_req", {31'd0, data_req}, 32'd0);
        chk("add_ready_go", {31'd0, ready_go}, 32'd1);
        chk("add_err", {31'd0, addr_err_o}, 32'd0);
        chk("add_pc", pc_o, 32'h101C);
        chk("add_alu", alu_o, 32'h5);
        tick();

        // SW 0x108 held in DONE by a W stall
        load_instr(32'h1020, 32'hAC00_0008, 32'h108, 32'h1122_3344, 1'b0, 1'b1, 2'd2);
        data_addr_ok = 1'b1;
        tick(); bubble(); allowin_next = 1'b0; #1;
        chk("st_req", {31'd0, data_req}, 32'd1);
        chk("st_allowin", {31'd0, allowin}, 32'd0);
        tick(); #1;
        chk("stall_ready_go", {31'd0, ready_go}, 32'd1);
        chk("stall_req", {31'd0, data_req}, 32'd0);
        chk("stall_allowin", {31'd0, allowin}, 32'd0);
        tick(); #1;
        chk("stall_valid", {31'd0, valid}, 32'd1);
        chk("stall_req2", {31'd0, data_req}, 32'd0);
        chk("stall_pc", pc_o, 32'h1020);
        allowin_next = 1'b1; data_addr_ok = 1'b0;
        tick();

        // SW data phase still pending: next LW waits; reset clears the count
        load_instr(32'h1024, 32'h8C00_000C, 32'h10C, 32'h0, 1'b1, 1'b0, 2'd2);
        tick(); bubble(); #1;
        chk("rw_wait_req", {31'd0, data_req}, 32'd0);
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("rw_valid", {31'd0, valid}, 32'd0);
        chk("rw_allowin", {31'd0, allowin}, 32'd1);
        load_instr(32'h1028, 32'h8C00_0010, 32'h110, 32'h0, 1'b1, 1'b0, 2'd2);
        tick(); bubble(); #1;
        chk("post_rst_req", {31'd0, data_req}, 32'd1);

        // Reset while a request is pending
        reset = 1'b1;
        tick(); reset = 1'b0; #1;
        chk("rr_req", {31'd0, data_req}, 32'd0);
        chk("rr_valid", {31'd0, valid}, 32'd0);
        chk("rr_allowin", {31'd0, allowin}, 32'd1);
        chk("rr_ready_go", {31'd0, ready_go}, 32'd1);
        load_instr(32'h102C, 32'h8C00_0014, 32'h114, 32'h0, 1'b1, 1'b0, 2'd2);
        tick(); bubble(); #1;
        chk("final_req", {31'd0, data_req}, 32'd1);
        chk("final_addr", data_addr, 32'h114);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_req_stage.md
Name: mem_req_stage

Overview:
- Memory (M) pipeline stage: sits between the execute stage and the writeback stage.
- Holds the M pipeline register under the valid/allowin handshake and issues load/store requests on the data bus (req / addr_ok / data_ok protocol).
- Passes each instruction to writeback once the address phase is accepted; writeback then consumes `data_data_ok`/`data_rdata`.
- Tracks outstanding data-phase transactions; generates store byte strobes, replicated write data and misalignment flags.

Parameters:
- MAX_OST, 1, maximum outstanding data-bus transactions (address accepted, data_ok pending); the counter is sized for values up to 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_last  in  1  upstream (E) holds a valid instruction
- allowin  out  1  M can accept from E this cycle
- allowin_next  in  1  W can accept from M
- ready_go  out  1  M instruction may leave this cycle
- valid  out  1  M register holds a valid instruction
- pc_i / pc_o  in/out  32  instruction PC
- instr_i / instr_o  in/out  32  instruction word
- alu_i / alu_o  in/out  32  ALU result (the memory address for load/store)
- ext_i, mdu_i, cp0_i / ext_o, mdu_o, cp0_o  in/out  32 each  carried operands
- rt_i  in  32  store source data
- mem_load_i, mem_store_i  in  1 each  instruction is load / store (never both)
- mem_size_i  in  2  0 byte, 1 half, 2 word (3 reserved, treated as word)
- addr_err_o  out  1  registered instruction is misaligned (AdEL/AdES to downstream)
- data_req  out  1  request valid
- data_wr  out  1  1 store, 0 load
- data_size  out  2  = registered mem_size
- data_addr  out  32  = registered alu value
- data_wdata  out  32  replicated store data
- data_wstrb  out  4  byte enables (0 for loads)
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase complete (also consumed by W)

Behaviour:
- Pipeline handshake:
  - allowin = !valid || (ready_go && allowin_next).
  - On clk with allowin: valid <= valid_last; when valid_last=1, all *_i fields are latched.
  - Outputs *_o are the registered copies.
- Reset values (synchronous):
  - valid=0; all registered fields 0; state=IDLE; outstanding count=0.
  - Hence data_req=0, ready_go=1, allowin=1, addr_err_o=0.
- Misalignment:
  - half with addr[0]=1 -> misaligned; word with addr[1:0]!=0 -> misaligned.
  - addr_err_o = valid && (load||store) && misaligned.
  - A misaligned access never raises data_req.
- Store data and strobes:
  - byte: wdata={4{rt[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - half: wdata={2{rt[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011.
  - word: wdata=rt, wstrb=4'b1111.
  - load: wstrb=0.
- FSM (one state per resident instruction):
  - On latch of a valid, aligned load/store: go to REQ if an issue slot is free, else WAIT.
  - Any other latch, or a bubble: go to IDLE.
  - WAIT -> REQ when a slot is free.
  - REQ: data_req=1; req, wr, size, addr, wdata and wstrb are held stable until addr_ok.
  - REQ -> DONE on data_addr_ok.
  - DONE holds until the instruction leaves. If a new instruction is latched in the same cycle the old one leaves, the new instruction's state applies.
- Issue slot free: ost < MAX_OST, or (ost == MAX_OST && data_data_ok) this cycle.
- Outstanding counter:
  - +1 on data_req&&data_addr_ok; -1 on data_data_ok; both in the same cycle -> unchanged.
  - Never exceeds MAX_OST; data_data_ok with ost=0 is ignored.
- ready_go = !valid || !(load||store) || addr_err_o || state==DONE.
  - ready_go is 0 in WAIT and REQ, which stalls E through allowin.
- Latency: an aligned access with an immediate addr_ok and a free slot is in REQ for 1 cycle and leaves on the next cycle it reaches DONE with allowin_next=1. The minimum is 2 cycles in M.
- A W stall (allowin_next=0) in DONE keeps the instruction resident. No second request is issued.
- Reset mid-request drops the request and clears the counter. The data bus is reset in the same cycle.

Test Plan:
- SW to 0x100, rt=0xDEADBEEF, addr_ok in the same cycle as req -> one req cycle with wr=1, wstrb=1111, wdata=0xDEADBEEF; ready_go=1 the next cycle; ost=1 until data_ok.
- SB addr 0x103, rt=0x000000A5 -> wstrb=1000, wdata=0xA5A5A5A5; SH addr 0x102, rt=0x1234 -> wstrb=1100, wdata=0x12341234.
- LW addr 0x104 with addr_ok delayed 3 cycles -> req, addr and size stable for 4 cycles; allowin=0 throughout; one transaction counted.
- Back-to-back LW, LW with MAX_OST=1 and data_ok for the first arriving 2 cycles after its addr_ok -> the second stays in WAIT (req=0) until the data_ok cycle; req rises the same cycle data_ok is seen.
- LH addr 0x101 -> addr_err_o=1, data_req never asserted, ready_go=1 immediately; non-memory ADD passes through in 1 cycle with req=0.
- reset asserted while req=1 and addr_ok=0 -> the next cycle req=0, valid=0, allowin=1, ost=0.
